// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache between the fetch
// stage and the unified backing memory.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-low reset (0 = reset)
//   PCF_i       fetch address, bits [1:0] ignored
//   ReqF_i      fetch request valid
//   InstrF_o    instruction word on a hit, NOP (0x00000013) otherwise
//   StallF_o    fetch must hold PCF_i and not advance
//   MemReq_o    registered line-refill request to backing memory
//   MemAddr_o   registered line-aligned refill address
//   MemValid_i  one refill data beat present this cycle
//   MemData_i   refill data beat
//
// Hits are answered combinationally in the lookup cycle. A miss moves the
// FSM to REFILL, which collects WORDS beats in ascending word order (gap
// cycles allowed) and then marks the line valid.
module instr_cache #(
    parameter int WIDTH = 32,
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCF_i,
    input  logic             ReqF_i,
    output logic [WIDTH-1:0] InstrF_o,
    output logic             StallF_o,
    output logic             MemReq_o,
    output logic [WIDTH-1:0] MemAddr_o,
    input  logic             MemValid_i,
    input  logic [WIDTH-1:0] MemData_i
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = WIDTH - OB - IB - 2;
    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);
    localparam logic [OB-1:0]    LAST_BEAT = OB'(WORDS - 1);
    localparam logic [OB-1:0]    BEAT_ONE  = OB'(32'd1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    state_t           state_r;
    logic [OB-1:0]    beat_cnt_r;
    logic [IB-1:0]    line_idx_r;
    logic [TW-1:0]    line_tag_r;
    logic [LINES-1:0] valid_r;
    logic             mem_req_r;
    logic [WIDTH-1:0] mem_addr_r;
    logic [TW-1:0]    tag_r  [LINES];
    logic [WIDTH-1:0] data_r [LINES][WORDS];

    logic [OB-1:0] word_sel_s;
    logic [IB-1:0] index_s;
    logic [TW-1:0] tag_s;
    logic          hit_s;
    logic          unused_pc_s;

    assign word_sel_s  = PCF_i[OB+1:2];
    assign index_s     = PCF_i[OB+IB+1:OB+2];
    assign tag_s       = PCF_i[WIDTH-1:OB+IB+2];
    assign unused_pc_s = ^PCF_i[1:0];

    // Hit detection: only an IDLE lookup can hit.
    always_comb begin
        hit_s = 1'b0;
        if (ReqF_i && (state_r == ST_IDLE) && valid_r[index_s] &&
            (tag_r[index_s] == tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Fetch-side response, same cycle as the presented PC.
    always_comb begin
        InstrF_o = NOP;
        StallF_o = 1'b0;
        if (state_r == ST_REFILL) begin
            StallF_o = 1'b1;
        end else if (hit_s) begin
            InstrF_o = data_r[index_s][word_sel_s];
        end else if (ReqF_i) begin
            StallF_o = 1'b1;
        end else begin
            StallF_o = 1'b0;
        end
    end

    // Lookup/refill FSM with valid bits and the registered memory request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= {OB{1'b0}};
            line_idx_r <= {IB{1'b0}};
            line_tag_r <= {TW{1'b0}};
            valid_r    <= {LINES{1'b0}};
            mem_req_r  <= 1'b0;
            mem_addr_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ReqF_i && !hit_s) begin
                        state_r    <= ST_REFILL;
                        line_idx_r <= index_s;
                        line_tag_r <= tag_s;
                        // Drop the victim now so a half-written line never hits.
                        valid_r[index_s] <= 1'b0;
                        beat_cnt_r <= {OB{1'b0}};
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= {PCF_i[WIDTH-1:OB+2], {(OB+2){1'b0}}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REFILL: begin
                    if (MemValid_i) begin
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r             <= ST_IDLE;
                            valid_r[line_idx_r] <= 1'b1;
                            beat_cnt_r          <= {OB{1'b0}};
                            mem_req_r           <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
                        end
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    beat_cnt_r <= {OB{1'b0}};
                    mem_req_r  <= 1'b0;
                end
            endcase
        end
    end

    // Data and tag storage; contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (rst && (state_r == ST_REFILL) && MemValid_i) begin
            data_r[line_idx_r][beat_cnt_r] <= MemData_i;
            if (beat_cnt_r == LAST_BEAT) begin
                tag_r[line_idx_r] <= line_tag_r;
            end else begin
                tag_r[line_idx_r] <= tag_r[line_idx_r];
            end
        end else begin
            data_r[line_idx_r][beat_cnt_r] <= data_r[line_idx_r][beat_cnt_r];
        end
    end

    assign MemReq_o  = mem_req_r;
    assign MemAddr_o = mem_addr_r;

endmodule

// File: tb/tb_instr_cache.sv
// Testbench for instr_cache: a directed table, hand-written multi-cycle
// sequences (gapped refill, reset mid-refill) and randomized fetch traffic,
// all checked against a line-level model of the cache held in the bench.
module tb_instr_cache;

    localparam int WIDTH = 32;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PCF_i;
    logic        ReqF_i;
    logic [31:0] InstrF_o;
    logic        StallF_o;
    logic        MemReq_o;
    logic [31:0] MemAddr_o;
    logic        MemValid_i;
    logic [31:0] MemData_i;

    int checks = 0;
    int errors = 0;

    instr_cache #(.WIDTH(WIDTH), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .PCF_i(PCF_i), .ReqF_i(ReqF_i),
        .InstrF_o(InstrF_o), .StallF_o(StallF_o), .MemReq_o(MemReq_o),
        .MemAddr_o(MemAddr_o), .MemValid_i(MemValid_i), .MemData_i(MemData_i)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Model: which line address each index holds, plus the refill in flight.
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    logic [31:0] m_line  = 32'd0;
    int          m_beats = 0;
    logic [31:0] m_addr  = 32'd0;
    bit          m_valid   [LINES];
    logic [31:0] m_line_of [LINES];
    int          stall_cnt = 0;

    typedef struct {
        logic        rs;
        logic        rq;
        logic [31:0] pc;
        logic        mv;
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
    } row_t;

    row_t tab [18];
    bit   tab_en  = 1'b0;
    int   tab_idx = 0;

    // Backing memory contents: line 0 holds 0x11..0x44, elsewhere unique words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'd0) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
        else return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic rs, input logic rq, input logic [31:0] pc, input logic mv);
        logic [31:0] line;
        int          idx;
        bit          hit;
        logic [31:0] e_instr;
        logic        e_stall;
        rst        = rs;
        ReqF_i     = rq;
        PCF_i      = pc;
        MemValid_i = mv;
        MemData_i  = (mv && m_busy) ? mem_word(m_line + 32'(4 * m_beats)) : $urandom();
        line    = {pc[31:4], 4'd0};
        idx     = int'(pc[7:4]);
        hit     = !m_busy && rq && m_valid[idx] && (m_line_of[idx] == line);
        e_instr = hit ? mem_word(pc) : NOP;
        e_stall = m_busy || (rq && !hit);
        @(negedge clk);
        if (StallF_o === 1'b1) stall_cnt++;
        if (m_known) begin
            check("model_instr", InstrF_o, e_instr);
            check("model_stall", 32'(StallF_o), 32'(e_stall));
            check("model_memreq", 32'(MemReq_o), 32'(m_busy));
            check("model_memaddr", MemAddr_o, m_addr);
        end
        if (tab_en) begin
            check($sformatf("row%0d_instr", tab_idx), InstrF_o, tab[tab_idx].e_instr);
            check($sformatf("row%0d_stall", tab_idx), 32'(StallF_o), 32'(tab[tab_idx].e_stall));
            check($sformatf("row%0d_memreq", tab_idx), 32'(MemReq_o), 32'(tab[tab_idx].e_req));
            check($sformatf("row%0d_memaddr", tab_idx), MemAddr_o, tab[tab_idx].e_addr);
        end
        @(posedge clk);
        if (!rs) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_addr  = 32'd0;
            m_beats = 0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (m_known) begin
            if (m_busy) begin
                if (mv) begin
                    m_beats++;
                    if (m_beats == WORDS) begin
                        m_valid[int'(m_line[7:4])]   = 1'b1;
                        m_line_of[int'(m_line[7:4])] = m_line;
                        m_busy = 1'b0;
                    end
                end
            end else if (rq && !hit) begin
                m_busy       = 1'b1;
                m_line       = line;
                m_beats      = 0;
                m_addr       = line;
                m_valid[idx] = 1'b0;
            end
        end
        #1;
    endtask

    logic [31:0] rpc;
    logic        rs_v, rq_v, mv_v;
    logic [6:0]  gap_pat;

    initial begin
        //          rs    rq    pc             mv    instr           stall req   addr
        tab[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, NOP,            1'b0, 1'b0, 32'h0};
        tab[1]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, NOP,            1'b1, 1'b0, 32'h0};
        tab[2]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, NOP,            1'b1, 1'b1, 32'h0};
        tab[3]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, NOP,            1'b1, 1'b1, 32'h0};
        tab[4]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, NOP,            1'b1, 1'b1, 32'h0};
        tab[5]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, NOP,            1'b1, 1'b1, 32'h0};
        tab[6]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0011,  1'b0, 1'b0, 32'h0};
        tab[7]  = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0022,  1'b0, 1'b0, 32'h0};
        tab[8]  = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0033,  1'b0, 1'b0, 32'h0};
        tab[9]  = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0044,  1'b0, 1'b0, 32'h0};
        tab[10] = '{1'b1, 1'b0, 32'h0000_1234, 1'b1, NOP,            1'b0, 1'b0, 32'h0};
        tab[11] = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, NOP,            1'b0, 1'b0, 32'h0};
        tab[12] = '{1'b1, 1'b1, 32'h0000_0100, 1'b0, NOP,            1'b1, 1'b0, 32'h0};
        tab[13] = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, NOP,            1'b1, 1'b1, 32'h100};
        tab[14] = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, NOP,            1'b1, 1'b1, 32'h100};
        tab[15] = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, NOP,            1'b1, 1'b1, 32'h100};
        tab[16] = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, NOP,            1'b1, 1'b1, 32'h100};
        tab[17] = '{1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'hC0DE_0104,  1'b0, 1'b0, 32'h100};

        // First reset cycle: outputs are still unknown before the first edge.
        step(1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            tab_idx = i;
            tab_en  = 1'b1;
            step(tab[i].rs, tab[i].rq, tab[i].pc, tab[i].mv);
        end
        tab_en = 1'b0;

        // 0x0 was evicted by 0x100: refill it with gapped beats 1,0,0,1,1,0,1.
        stall_cnt = 0;
        gap_pat   = 7'b1011001;
        step(1'b1, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 32'h0, gap_pat[i]);
        step(1'b1, 1'b1, 32'h0, 1'b0);
        check("gap_stall_cycles", 32'(stall_cnt), 32'd8);
        step(1'b1, 1'b1, 32'h4, 1'b0);
        step(1'b1, 1'b1, 32'h8, 1'b0);
        step(1'b1, 1'b1, 32'hC, 1'b0);

        // Reset after two beats, then stray beats while idle.
        step(1'b1, 1'b1, 32'h200, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check("memreq_after_reset", 32'(MemReq_o), 32'd0);
        check("memaddr_after_reset", MemAddr_o, 32'd0);
        step(1'b1, 1'b0, 32'h200, 1'b1);
        step(1'b1, 1'b0, 32'h200, 1'b1);
        check("memreq_stray_beats", 32'(MemReq_o), 32'd0);
        stall_cnt = 0;
        step(1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        check("refetch_stall_cycles", 32'(stall_cnt), 32'd5);
        check("refetch_word0", InstrF_o, 32'hC0DE_0200);

        // Random traffic over a few conflicting lines; PC held while refilling.
        rpc = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!m_busy) begin
                rpc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
                          ($urandom_range(0, 3) << 2));
            end
            rq_v = ($urandom_range(0, 9) != 0);
            mv_v = ($urandom_range(0, 9) < 7);
            rs_v = ($urandom_range(0, 99) != 0);
            step(rs_v, rq_v, rpc, mv_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache. It is the responder to the fetch stage's instruction read: it takes the fetch PC, returns the instruction word in the same cycle on a hit, and stalls fetch on a miss. During a miss it refills a whole line from backing memory through a request/valid beat handshake. It sits between the fetch stage and the unified backing memory, replacing the flat combinational instruction memory.

## Interface
- WIDTH, 32: address and data width.
- LINES, 16: number of cache lines; power of two, at least 2.
- WORDS, 4: 32-bit words per line; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- PCF_i  in  WIDTH  fetch address; bits [1:0] ignored.
- ReqF_i  in  1  fetch request valid.
- InstrF_o  out  WIDTH  instruction word; 0x00000013 (NOP) when not a hit.
- StallF_o  out  1  fetch must hold PCF_i and not advance.
- MemReq_o  out  1  line-refill request to backing memory.
- MemAddr_o  out  WIDTH  line-aligned refill address: offset bits zero.
- MemValid_i  in  1  one refill data beat is present this cycle.
- MemData_i  in  WIDTH  refill data beat.

## Operation
- **Address split** (OB = log2(WORDS), IB = log2(LINES)):
  - word select = PCF_i[OB+1:2]
  - index = PCF_i[OB+IB+1:OB+2]
  - tag = PCF_i[WIDTH-1:OB+IB+2]
- **Storage:** per line, a valid bit, a tag, and WORDS data words.
- **Hit:** ReqF_i=1, state IDLE, valid[index]=1, tag match. InstrF_o is the stored word, StallF_o=0. Both are combinational, in the same cycle as PCF_i.
- **Miss:** ReqF_i=1, state IDLE, not a hit. StallF_o=1 and InstrF_o=NOP. The FSM moves to REFILL on the next edge and latches the line address.
- **ReqF_i=0:** InstrF_o=NOP, StallF_o=0 in IDLE. No state change.
- **FSM states:**
  - IDLE: hit or miss lookup as above.
  - REFILL:
    - MemReq_o=1, MemAddr_o = latched line address, StallF_o=1, InstrF_o=NOP.
    - Each cycle with MemValid_i=1, MemData_i is written to word beat_cnt of the line and beat_cnt increments.
    - When the beat with beat_cnt=WORDS-1 is accepted: set valid[index], write the tag, clear beat_cnt, return to IDLE.
- **Refill beats:**
  - Beats arrive in ascending word order and may have gap cycles (MemValid_i=0).
  - Before the line is written, valid[index] is cleared on REFILL entry, so an evicted line never hits with mixed data.
  - MemValid_i outside REFILL is ignored.
- **Fetch-side rules:**
  - PCF_i must stay stable while StallF_o=1; behaviour with a changing PCF_i is undefined.
  - A refill already started completes even if ReqF_i drops.
- **Replacement:** a miss to a valid index overwrites that line unconditionally.
- **Reset (rst=0 at an edge):**
  - All valid bits clear, FSM goes to IDLE, beat_cnt=0.
  - Next-cycle outputs: MemReq_o=0, MemAddr_o=0, StallF_o=0 unless a miss is presented.
  - Reset mid-refill aborts the refill; the partial line stays invalid.
- No write port and no self-modifying-code coherence.

## Timing
- Hit latency: 0 cycles (combinational read).
- Miss penalty with back-to-back beats: cycle 0 miss detected; cycles 1..WORDS are beats; cycle WORDS+1 hits. StallF_o is high for WORDS+1 cycles (5 at default).
- Each gap cycle on MemValid_i adds one stall cycle.
- MemReq_o and MemAddr_o are registered: they rise on the edge after the miss and fall on the edge that accepts the last beat.
- Data and tag arrays are registered storage. Valid bits reset synchronously; data arrays need no reset.

## Test plan
- **Cold miss:** rst held low 2 cycles, then ReqF_i=1, PCF_i=0x00000000, memory returns 0x11,0x22,0x33,0x44 back-to-back.
  - MemReq_o high in cycles 1-4 with MemAddr_o=0x0; StallF_o high in cycles 0-4.
  - Cycle 5: InstrF_o=0x11, StallF_o=0.
- **Hits after fill:** PCF_i 0x4, 0x8, 0xC on consecutive cycles → 0x22, 0x33, 0x44 with StallF_o=0 and MemReq_o=0.
- **Conflict eviction:** fetch 0x100 (index 0, tag 1) after 0x0 is filled → miss with MemAddr_o=0x100. After refill, fetching 0x0 misses again.
- **Gapped beats:** refill with MemValid_i pattern 1,0,0,1,1,0,1 → StallF_o high 8 cycles and correct words stored in order.
- **Reset mid-refill:** rst=0 after 2 of 4 beats, stray MemValid_i afterwards.
  - MemReq_o=0 the next cycle; stray beats ignored.
  - Re-fetch of the same PC misses and refills fully.
- **Idle fetch:** ReqF_i=0 → InstrF_o=0x00000013, StallF_o=0, no MemReq_o, for any PCF_i.
